// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM,
// redirects through a 32-entry jump-target LUT and sequences Start/Done.
module fetch_unit #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            Jump,
    input  logic [4:0]      Jptr,
    input  logic            lut_we,
    input  logic [4:0]      lut_waddr,
    input  logic [PC_W-1:0] lut_wdata,
    input  logic [PC_W-1:0] prog_end,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_en,
    input  logic [8:0]      imem_data,
    output logic [8:0]      mach_code,
    output logic            inst_valid,
    output logic [PC_W-1:0] inst_pc,
    output logic            Done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] lut [LUT_DEPTH];
    logic            jump_take;
    logic            end_hit;

    assign imem_addr = pc;
    assign imem_en   = (state == RUN) && !Stall;
    assign mach_code = imem_data;

    // A taken jump on the last instruction wins over program completion.
    assign jump_take = inst_valid && Jump;
    assign end_hit   = inst_valid && (inst_pc == prog_end) && !Jump;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= '0;
            inst_valid <= 1'b0;
            inst_pc    <= '0;
            Done       <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else begin
            if (lut_we) begin
                lut[lut_waddr] <= lut_wdata;
            end
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                RUN: begin
                    if (!Stall) begin
                        inst_pc <= pc;
                        if (jump_take) begin
                            // Word fetched this cycle is squashed; the LUT read sees the pre-write value.
                            pc         <= lut[Jptr];
                            inst_valid <= 1'b0;
                        end else if (end_hit) begin
                            state      <= DONE;
                            Done       <= 1'b1;
                            inst_valid <= 1'b0;
                        end else begin
                            pc         <= pc + PC_W'(1);
                            inst_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (Start) begin
                        state <= RUN;
                        pc    <= '0;
                        Done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start/done sequencing, jumps, stalls, LUT
// write/read collision, reset mid-run and PC wrap on a narrow build.
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset, Start, Stall, Jump, lut_we;
    logic [4:0] Jptr, lut_waddr;
    logic [9:0] lut_wdata, prog_end, imem_addr, inst_pc;
    logic       imem_en, inst_valid, Done;
    logic [8:0] imem_data, mach_code;

    logic       w_reset, w_start, w_imem_en, w_inst_valid, w_done;
    logic [3:0] w_imem_addr, w_inst_pc;
    logic [8:0] w_imem_data, w_mach_code;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    fetch_unit #(.PC_W(10), .LUT_DEPTH(32)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Jump(Jump), .Jptr(Jptr),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .prog_end(prog_end),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .mach_code(mach_code), .inst_valid(inst_valid), .inst_pc(inst_pc), .Done(Done)
    );

    fetch_unit #(.PC_W(4), .LUT_DEPTH(32)) dut_w (
        .Clk(Clk), .Reset(w_reset), .Start(w_start), .Stall(1'b0), .Jump(1'b0), .Jptr(5'd0),
        .lut_we(1'b0), .lut_waddr(5'd0), .lut_wdata(4'd0), .prog_end(4'd15),
        .imem_addr(w_imem_addr), .imem_en(w_imem_en), .imem_data(w_imem_data),
        .mach_code(w_mach_code), .inst_valid(w_inst_valid), .inst_pc(w_inst_pc), .Done(w_done)
    );

    // ROM contents: word at address a is 9'h040 + a; output holds while disabled.
    always @(posedge Clk) if (imem_en) imem_data <= 9'h040 + 9'(imem_addr);
    always @(posedge Clk) if (w_imem_en) w_imem_data <= 9'h040 + 9'(w_imem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1; Start = 0; Stall = 0; Jump = 0; Jptr = 0;
        lut_we = 0; lut_waddr = 0; lut_wdata = 0; prog_end = 10'd3;
        w_reset = 1; w_start = 0;
        step(); step();
        Reset = 0; w_reset = 0;
        chk("rst_valid", inst_valid, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_done", Done, 0);
        chk("rst_en", imem_en, 0);

        // Straight-line program 0..3
        Start = 1; step(); Start = 0;
        chk("first_en", imem_en, 1);
        chk("first_addr", imem_addr, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            chk("seq_pc", inst_pc, k);
            chk("seq_valid", inst_valid, 1);
            chk("seq_code", mach_code, 9'h040 + k);
            step();
        end
        chk("end_done", Done, 1);
        chk("end_valid", inst_valid, 0);
        for (int k = 0; k < 3; k++) begin
            chk("done_en_off", imem_en, 0);
            chk("done_hold", Done, 1);
            step();
        end

        // Load LUT[5]=20, LUT[2]=7 while in DONE, then restart
        lut_we = 1; lut_waddr = 5; lut_wdata = 10'd20; step();
        lut_waddr = 2; lut_wdata = 10'd7; step();
        lut_we = 0; prog_end = 10'd100;
        Start = 1; step(); Start = 0;
        chk("restart_done", Done, 0);
        chk("restart_addr", imem_addr, 0);
        step(); step(); step();
        chk("pre_jump_pc", inst_pc, 2);
        Jump = 1; Jptr = 5; step(); Jump = 0;
        chk("jump_bubble", inst_valid, 0);
        step();
        chk("jump_tgt_pc", inst_pc, 20);
        chk("jump_tgt_valid", inst_valid, 1);
        chk("jump_tgt_code", mach_code, 9'h040 + 20);

        // Jump to 7, then stall three cycles there
        Jump = 1; Jptr = 2; step(); Jump = 0;
        step();
        chk("at7_pc", inst_pc, 7);
        Stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_en", imem_en, 0);
            step();
            chk("stall_pc", inst_pc, 7);
            chk("stall_valid", inst_valid, 1);
            chk("stall_code", mach_code, 9'h047);
        end
        Stall = 0; step();
        chk("unstall_pc", inst_pc, 8);
        chk("unstall_code", mach_code, 9'h048);

        // Jump through entry 5 while rewriting it: old value used, new value later
        Jump = 1; Jptr = 5; lut_we = 1; lut_waddr = 5; lut_wdata = 10'd30; step();
        Jump = 0; lut_we = 0;
        chk("wr_jump_bubble", inst_valid, 0);
        step();
        chk("wr_jump_old", inst_pc, 20);
        Jump = 1; Jptr = 5; step(); Jump = 0;
        step();
        chk("wr_jump_new", inst_pc, 30);

        // Jump taken on the prog_end instruction suppresses Done
        prog_end = 10'd31;
        step();
        chk("at_end_pc", inst_pc, 31);
        Jump = 1; Jptr = 2; step(); Jump = 0;
        chk("jend_done", Done, 0);
        step();
        chk("jend_pc", inst_pc, 7);
        chk("jend_done2", Done, 0);

        // Finish at 9, then restart from DONE
        prog_end = 10'd9;
        step(); step();
        chk("pc9", inst_pc, 9);
        step();
        chk("done9", Done, 1);
        Start = 1; step(); Start = 0;
        chk("rs_done", Done, 0);
        chk("rs_en", imem_en, 1);
        chk("rs_addr", imem_addr, 0);
        prog_end = 10'd100;
        step();
        chk("rs_pc0", inst_pc, 0);
        chk("rs_valid", inst_valid, 1);

        // Reset mid-run at inst_pc=12
        for (int k = 0; k < 12; k++) step();
        chk("pre_rst_pc", inst_pc, 12);
        Reset = 1; step(); Reset = 0;
        chk("mid_rst_valid", inst_valid, 0);
        chk("mid_rst_done", Done, 0);
        chk("mid_rst_en", imem_en, 0);
        chk("mid_rst_pc", inst_pc, 0);
        Start = 1; step(); Start = 0;
        step();
        Jump = 1; Jptr = 5; step(); Jump = 0;
        step();
        chk("lut_cleared_pc", inst_pc, 0);
        chk("lut_cleared_valid", inst_valid, 1);

        // Narrow build: PC wraps from 15 to 0
        w_start = 1; step(); w_start = 0;
        step();
        for (int k = 0; k < 15; k++) step();
        chk("w_pc15", w_inst_pc, 15);
        chk("w_wrap_addr", w_imem_addr, 0);
        chk("w_wrap_en", w_imem_en, 1);
        step();
        chk("w_done", w_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
